branch: RTL and testbench

BRANCH -- requirements
Module: branch

---
 rtl/branch.sv | 154 +++++++++++++++
 tb/tb_branch.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch.sv
// Branch unit: decodes relative / absolute / indirect branches, evaluates the
// word / halfword zero conditions, computes the target PC and link value, and
// registers every result for a fixed one-cycle latency.
module branch (
    input  logic         clk,
    input  logic         reset,
    input  logic [0:10]  op,
    input  logic [2:0]   format,
    input  logic [0:6]   rt_addr,
    input  logic [0:127] ra,
    input  logic [0:127] rb,
    input  logic [0:127] rt_st,
    input  logic [0:17]  imm,
    input  logic         reg_write,
    input  logic [7:0]   pc_in,
    input  logic         first,
    output logic [0:127] rt_wb,
    output logic [0:6]   rt_addr_wb,
    output logic         reg_write_wb,
    output logic [7:0]   pc_wb,
    output logic         branch_taken,
    output logic         branch_kill
);

    localparam logic [2:0] FMT_RR   = 3'd0;
    localparam logic [2:0] FMT_RI16 = 3'd5;

    // RI16 opcodes live in op[2:10]
    localparam logic [8:0] OP_BR    = 9'b001100100;
    localparam logic [8:0] OP_BRA   = 9'b001100000;
    localparam logic [8:0] OP_BRSL  = 9'b001100110;
    localparam logic [8:0] OP_BRASL = 9'b001100010;
    localparam logic [8:0] OP_BRZ   = 9'b001000000;
    localparam logic [8:0] OP_BRNZ  = 9'b001000010;
    localparam logic [8:0] OP_BRHZ  = 9'b001000100;
    localparam logic [8:0] OP_BRHNZ = 9'b001000110;

    // RR opcodes use the full op[0:10]
    localparam logic [10:0] OP_BI   = 11'b00110101000;
    localparam logic [10:0] OP_BISL = 11'b00110101001;
    localparam logic [10:0] OP_BIZ  = 11'b00100101000;
    localparam logic [10:0] OP_BINZ = 11'b00100101001;

    typedef enum logic [2:0] {C_ALWAYS, C_Z, C_NZ, C_HZ, C_HNZ} cond_e;
    typedef enum logic [1:0] {T_REL, T_ABS, T_IND} tgt_e;

    logic         w_valid;
    logic         w_link;
    cond_e        w_cc;
    tgt_e         w_tk;
    logic         w_cond;
    logic         w_taken;
    logic [31:0]  w_word;
    logic [15:0]  w_half;
    logic [7:0]   w_target;
    logic [7:0]   w_link_pc;
    logic [31:0]  w_link_val;
    logic         w_unused;

    logic [0:127] r_rt_wb;
    logic [0:6]   r_rt_addr_wb;
    logic         r_reg_write_wb;
    logic [7:0]   r_pc_wb;
    logic         r_taken;
    logic         r_kill;

    assign w_word = rt_st[0:31];
    assign w_half = rt_st[16:31];

    // Only a byte of the target survives, so only imm[10:17] and ra[22:29]
    // matter; the rest of the operands are deliberately ignored.
    assign w_unused = ^{rb, ra[0:21], ra[30:127], rt_st[32:127], imm[0:9]};

    // Opcode decode: classify target kind, condition and link behaviour
    always_comb begin
        w_valid = 1'b0;
        w_link  = 1'b0;
        w_cc    = C_ALWAYS;
        w_tk    = T_REL;
        if (format == FMT_RI16) begin
            case (op[2:10])
                OP_BR:    begin w_valid = 1'b1; end
                OP_BRA:   begin w_valid = 1'b1; w_tk = T_ABS; end
                OP_BRSL:  begin w_valid = 1'b1; w_link = 1'b1; end
                OP_BRASL: begin w_valid = 1'b1; w_tk = T_ABS; w_link = 1'b1; end
                OP_BRZ:   begin w_valid = 1'b1; w_cc = C_Z; end
                OP_BRNZ:  begin w_valid = 1'b1; w_cc = C_NZ; end
                OP_BRHZ:  begin w_valid = 1'b1; w_cc = C_HZ; end
                OP_BRHNZ: begin w_valid = 1'b1; w_cc = C_HNZ; end
                default:  ;
            endcase
        end else if (format == FMT_RR) begin
            case (op)
                OP_BI:    begin w_valid = 1'b1; w_tk = T_IND; end
                OP_BISL:  begin w_valid = 1'b1; w_tk = T_IND; w_link = 1'b1; end
                OP_BIZ:   begin w_valid = 1'b1; w_tk = T_IND; w_cc = C_Z; end
                OP_BINZ:  begin w_valid = 1'b1; w_tk = T_IND; w_cc = C_NZ; end
                default:  ;
            endcase
        end
    end

    // Condition evaluation on the preferred word / halfword of rt_st
    always_comb begin
        w_cond = 1'b1;
        case (w_cc)
            C_Z:     w_cond = (w_word == 32'd0);
            C_NZ:    w_cond = (w_word != 32'd0);
            C_HZ:    w_cond = (w_half == 16'd0);
            C_HNZ:   w_cond = (w_half != 16'd0);
            default: w_cond = 1'b1;
        endcase
    end

    // Target select; relative add is 8 bits wide so it wraps mod 256 both ways
    always_comb begin
        case (w_tk)
            T_ABS:   w_target = imm[10:17];
            T_IND:   w_target = ra[22:29];
            default: w_target = pc_in + imm[10:17];
        endcase
    end

    assign w_taken    = w_valid & w_cond;
    assign w_link_pc  = pc_in + 8'd1;
    assign w_link_val = {22'd0, w_link_pc, 2'b00};

    // Output register stage; reset wins over any in-flight instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rt_wb        <= '0;
            r_rt_addr_wb   <= '0;
            r_reg_write_wb <= 1'b0;
            r_pc_wb        <= '0;
            r_taken        <= 1'b0;
            r_kill         <= 1'b0;
        end else begin
            r_rt_wb        <= (w_valid && w_link) ? {w_link_val, 96'd0} : '0;
            r_rt_addr_wb   <= rt_addr;
            r_reg_write_wb <= w_valid & w_link & reg_write;
            r_pc_wb        <= w_taken ? w_target : 8'd0;
            r_taken        <= w_taken;
            r_kill         <= w_taken & first;
        end
    end

    assign rt_wb        = r_rt_wb;
    assign rt_addr_wb   = r_rt_addr_wb;
    assign reg_write_wb = r_reg_write_wb;
    assign pc_wb        = r_pc_wb;
    assign branch_taken = r_taken;
    assign branch_kill  = r_kill;

endmodule

// File: tb/tb_branch.sv
// Directed + randomized bench for the branch unit. Expected results are
// queued when an instruction is driven and checked one cycle later.
module tb_branch;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [0:10]  op = '0;
    logic [2:0]   format = '0;
    logic [0:6]   rt_addr = '0;
    logic [0:127] ra = '0;
    logic [0:127] rb = '0;
    logic [0:127] rt_st = '0;
    logic [0:17]  imm = '0;
    logic         reg_write = 1'b0;
    logic [7:0]   pc_in = '0;
    logic         first = 1'b0;
    logic [0:127] rt_wb;
    logic [0:6]   rt_addr_wb;
    logic         reg_write_wb;
    logic [7:0]   pc_wb;
    logic         branch_taken;
    logic         branch_kill;

    branch dut (
        .clk(clk), .reset(reset), .op(op), .format(format), .rt_addr(rt_addr),
        .ra(ra), .rb(rb), .rt_st(rt_st), .imm(imm), .reg_write(reg_write),
        .pc_in(pc_in), .first(first), .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb),
        .reg_write_wb(reg_write_wb), .pc_wb(pc_wb), .branch_taken(branch_taken),
        .branch_kill(branch_kill)
    );

    always #5 clk = ~clk;

    localparam logic [0:10] BR    = 11'b00001100100;
    localparam logic [0:10] BRA   = 11'b00001100000;
    localparam logic [0:10] BRSL  = 11'b00001100110;
    localparam logic [0:10] BRASL = 11'b00001100010;
    localparam logic [0:10] BRZ   = 11'b00001000000;
    localparam logic [0:10] BRNZ  = 11'b00001000010;
    localparam logic [0:10] BRHZ  = 11'b00001000100;
    localparam logic [0:10] BRHNZ = 11'b00001000110;
    localparam logic [0:10] BI    = 11'b00110101000;
    localparam logic [0:10] BISL  = 11'b00110101001;
    localparam logic [0:10] BIZ   = 11'b00100101000;
    localparam logic [0:10] BINZ  = 11'b00100101001;

    typedef struct {
        logic [0:127] rt;
        logic [0:6]   addr;
        logic         rw;
        logic [7:0]   pc;
        logic         tk;
        logic         kl;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_bad = 0;

    function automatic exp_t mk(logic [31:0] lnk, logic [0:6] a, logic rw,
                                logic [7:0] pc, logic tk, logic kl);
        exp_t e;
        e.rt = {lnk, 96'd0};
        e.addr = a; e.rw = rw; e.pc = pc; e.tk = tk; e.kl = kl;
        return e;
    endfunction

    // Reference model written from the opcode tables, using integer arithmetic
    function automatic exp_t model(logic [0:10] o, logic [2:0] f, logic [0:6] a,
                                   logic [0:127] r, logic [0:127] s, logic [0:17] im,
                                   logic rw, logic [7:0] pc, logic fi);
        exp_t e;
        int kind = 0;   // 0 none, 1 relative, 2 absolute, 3 indirect
        int cnd = 0;    // 0 always, 1 W==0, 2 W!=0, 3 H==0, 4 H!=0
        bit lk = 0;
        bit tk;
        int t = 0;
        logic [31:0] w;
        logic [31:0] x;
        w = s[0:31];
        if (f == 3'd5) begin
            if (o == BR) kind = 1;
            else if (o[2:10] == BRA[2:10]) kind = 2;
            else if (o[2:10] == BRSL[2:10]) begin kind = 1; lk = 1; end
            else if (o[2:10] == BRASL[2:10]) begin kind = 2; lk = 1; end
            else if (o[2:10] == BRZ[2:10]) begin kind = 1; cnd = 1; end
            else if (o[2:10] == BRNZ[2:10]) begin kind = 1; cnd = 2; end
            else if (o[2:10] == BRHZ[2:10]) begin kind = 1; cnd = 3; end
            else if (o[2:10] == BRHNZ[2:10]) begin kind = 1; cnd = 4; end
        end else if (f == 3'd0) begin
            if (o == BI) kind = 3;
            else if (o == BISL) begin kind = 3; lk = 1; end
            else if (o == BIZ) begin kind = 3; cnd = 1; end
            else if (o == BINZ) begin kind = 3; cnd = 2; end
        end
        if (o == BR && f != 3'd5) kind = 0;
        case (cnd)
            1: tk = (w == 0);
            2: tk = (w != 0);
            3: tk = (w % 65536 == 0);
            4: tk = (w % 65536 != 0);
            default: tk = 1;
        endcase
        if (kind == 0) tk = 0;
        if (kind == 1) t = ((int'(pc) + int'($signed(im[2:17]))) % 256 + 256) % 256;
        if (kind == 2) t = int'(im) % 256;
        if (kind == 3) begin x = r[0:31]; t = int'(x / 4) % 256; end
        e.addr = a;
        e.tk = tk;
        e.kl = tk && fi;
        e.pc = tk ? 8'(t) : 8'd0;
        e.rw = (kind != 0) && lk && rw;
        e.rt = '0;
        if (kind != 0 && lk) e.rt[0:31] = 32'(((int'(pc) + 1) % 256) * 4);
        return e;
    endfunction

    task automatic check(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            n_vec++; n_bad++;
            $error("FAIL %s: scoreboard empty, observed output with nothing expected", tag);
            return;
        end
        e = q.pop_front();
        n_vec++;
        assert (rt_wb === e.rt) else begin n_bad++;
            $error("FAIL %s.rt_wb: got %h want %h", tag, rt_wb, e.rt); end
        n_vec++;
        assert (rt_addr_wb === e.addr) else begin n_bad++;
            $error("FAIL %s.rt_addr_wb: got %0d want %0d", tag, rt_addr_wb, e.addr); end
        n_vec++;
        assert (reg_write_wb === e.rw) else begin n_bad++;
            $error("FAIL %s.reg_write_wb: got %b want %b", tag, reg_write_wb, e.rw); end
        n_vec++;
        assert (pc_wb === e.pc) else begin n_bad++;
            $error("FAIL %s.pc_wb: got %0d want %0d", tag, pc_wb, e.pc); end
        n_vec++;
        assert (branch_taken === e.tk) else begin n_bad++;
            $error("FAIL %s.branch_taken: got %b want %b", tag, branch_taken, e.tk); end
        n_vec++;
        assert (branch_kill === e.kl) else begin n_bad++;
            $error("FAIL %s.branch_kill: got %b want %b", tag, branch_kill, e.kl); end
    endtask

    // Drive one instruction, queue its expectation, check after the edge
    task automatic step(input string tag, input logic rst, input logic [0:10] o,
                        input logic [2:0] f, input logic [0:6] a, input logic [0:127] r,
                        input logic [0:127] s, input logic [0:17] im, input logic rw,
                        input logic [7:0] pc, input logic fi, input exp_t e);
        reset = rst; op = o; format = f; rt_addr = a; ra = r; rt_st = s;
        imm = im; reg_write = rw; pc_in = pc; first = fi;
        rb = {4{$urandom()}};
        q.push_back(e);
        @(posedge clk);
        #1;
        check(tag);
        @(negedge clk);
    endtask

    initial begin
        logic [0:127] z;
        logic [0:127] s;
        logic [0:127] r;
        logic [0:10]  o;
        logic [2:0]   f;
        logic [0:17]  im;
        logic [0:6]   a;
        logic [7:0]   pc;
        logic         rw;
        logic         fi;
        z = '0;
        @(negedge clk);

        step("reset", 1, BR, 5, 7'd3, z, z, 18'd5, 1, 8'd10, 1, mk(0, 0, 0, 0, 0, 0));
        step("br", 0, BR, 5, 7'd9, z, z, 18'd5, 0, 8'd10, 1, mk(0, 9, 0, 15, 1, 1));
        step("brsl", 0, BRSL, 5, 7'd3, z, z, {2'b00, 16'hFFFC}, 1, 8'd20, 0,
             mk(32'h54, 3, 1, 16, 1, 0));
        s = '0; s[0:31] = 32'd1;
        step("brz_nt", 0, BRZ, 5, 7'd4, z, s, 18'd3, 0, 8'd5, 1, mk(0, 4, 0, 0, 0, 0));
        s = '1; s[0:31] = 32'd0;
        step("brz_wrap", 0, BRZ, 5, 7'd4, z, s, 18'd10, 0, 8'd250, 0, mk(0, 4, 0, 4, 1, 0));
        r = '1; r[0:31] = 32'h100;
        step("bi", 0, BI, 0, 7'd1, r, z, 18'd0, 0, 8'd77, 1, mk(0, 1, 0, 8'h40, 1, 1));
        s = '0; s[0:31] = 32'hFFFF0000;
        step("brhz", 0, BRHZ, 5, 7'd2, z, s, 18'd2, 0, 8'd3, 0, mk(0, 2, 0, 5, 1, 0));
        step("badfmt", 0, BR, 2, 7'd5, z, z, 18'd5, 1, 8'd10, 1, mk(0, 5, 0, 0, 0, 0));
        step("bra", 0, BRA, 5, 7'd6, z, z, 18'h2F0AB, 0, 8'd1, 0, mk(0, 6, 0, 8'hAB, 1, 0));
        step("brasl_wrap", 0, BRASL, 5, 7'd127, z, z, 18'h00012, 1, 8'd255, 1,
             mk(0, 127, 1, 8'h12, 1, 1));
        r = '0; r[0:31] = 32'h3FC;
        step("bisl", 0, BISL, 0, 7'd8, r, z, 18'd0, 1, 8'd7, 1, mk(32'd32, 8, 1, 8'hFF, 1, 1));
        r = '0; r[0:31] = 32'h20;
        step("binz_nt", 0, BINZ, 0, 7'd0, r, z, 18'd0, 0, 8'd0, 1, mk(0, 0, 0, 0, 0, 0));
        s = '0; s[0:31] = 32'h80000000;
        step("binz", 0, BINZ, 0, 7'd0, r, s, 18'd0, 0, 8'd0, 1, mk(0, 0, 0, 8, 1, 1));
        step("biz_nt", 0, BIZ, 0, 7'd0, r, s, 18'd0, 0, 8'd0, 1, mk(0, 0, 0, 0, 0, 0));
        step("brnz_nt", 0, BRNZ, 5, 7'd0, z, z, 18'd1, 0, 8'd9, 0, mk(0, 0, 0, 0, 0, 0));
        s = '0; s[0:31] = 32'hFFFF0000;
        step("brhnz_nt", 0, BRHNZ, 5, 7'd0, z, s, 18'd1, 0, 8'd9, 0, mk(0, 0, 0, 0, 0, 0));
        s = '0; s[0:31] = 32'h00000001;
        step("brhnz", 0, BRHNZ, 5, 7'd0, z, s, {2'b00, 16'h8000}, 0, 8'd9, 0,
             mk(0, 0, 0, 8'd9, 1, 0));
        step("brsl_norw", 0, BRSL, 5, 7'd11, z, z, 18'd0, 0, 8'd0, 0, mk(32'd4, 11, 0, 0, 1, 0));
        r = '0; r[0:31] = 32'h100;
        step("midreset", 1, BISL, 0, 7'd12, r, z, 18'd0, 1, 8'd3, 1, mk(0, 0, 0, 0, 0, 0));
        step("postreset", 0, BR, 5, 7'd13, z, z, {2'b00, 16'hFFFF}, 0, 8'd0, 1,
             mk(0, 13, 0, 8'd255, 1, 1));

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 13))
                0: begin o = BR; f = 5; end      1: begin o = BRA; f = 5; end
                2: begin o = BRSL; f = 5; end    3: begin o = BRASL; f = 5; end
                4: begin o = BRZ; f = 5; end     5: begin o = BRNZ; f = 5; end
                6: begin o = BRHZ; f = 5; end    7: begin o = BRHNZ; f = 5; end
                8: begin o = BI; f = 0; end      9: begin o = BISL; f = 0; end
                10: begin o = BIZ; f = 0; end    11: begin o = BINZ; f = 0; end
                12: begin o = BR; f = 3'($urandom_range(1, 4)); end
                default: begin o = BI; f = 5; end
            endcase
            s = {4{$urandom()}};
            case ($urandom_range(0, 3))
                0: s[0:31] = 32'd0;
                1: s[0:31] = 32'hFFFF0000;
                2: s[0:31] = 32'h00000001;
                default: ;
            endcase
            r = {4{$urandom()}};
            im = 18'($urandom());
            a = 7'($urandom());
            pc = 8'($urandom());
            rw = 1'($urandom());
            fi = 1'($urandom());
            step("rand", 0, o, f, a, r, s, im, rw, pc, fi, model(o, f, a, r, s, im, rw, pc, fi));
        end

        if (q.size() != 0) begin
            n_vec++; n_bad++;
            $error("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
